stopwatch_ctrl: RTL and testbench

//  Run/pause/lap/clear sequencer for the stopwatch counter datapath.

---
 rtl/stopwatch_ctrl.sv | 143 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear sequencer for the stopwatch counters.
// Decodes go/lap button edges while the stopwatch is the selected application,
// produces the hundredths count enable and the counter clear pulse, and keeps
// a lap snapshot of the time that can be frozen on the display.
module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 100,
    parameter logic [10:0] OPC_STW = 11'b00001000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        lap,
    input  logic [10:0] op_code,
    input  logic [29:0] time_in,
    output logic        tick_en,
    output logic        sw_clr,
    output logic        lap_hold,
    output logic [29:0] time_out,
    output logic [1:0]  state
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic          go_q, go_d;
    logic          lap_q, lap_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_en_q, tick_en_d;
    logic          sw_clr_q, sw_clr_d;
    logic          lap_hold_q, lap_hold_d;
    logic [29:0]   snapshot_q, snapshot_d;

    logic          sel;
    logic          go_act;
    logic          lap_act;
    logic [PW-1:0] presc_inc;

    // Button edge detection, qualified by the stopwatch select; go has priority over lap.
    always_comb begin
        go_d    = go;
        lap_d   = lap;
        sel     = (op_code == OPC_STW);
        go_act  = sel & go & ~go_q;
        lap_act = sel & lap & ~lap_q & ~go_act;
    end

    // Run/pause/lap/clear next-state logic, including lap snapshot capture and the clear pulse.
    always_comb begin
        state_d    = state_q;
        lap_hold_d = lap_hold_q;
        snapshot_d = snapshot_q;
        sw_clr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go_act) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (go_act) begin
                    state_d = ST_PAUSE;
                end else if (lap_act) begin
                    lap_hold_d = ~lap_hold_q;
                    if (!lap_hold_q) begin
                        snapshot_d = time_in;
                    end
                end
            end
            ST_PAUSE: begin
                if (go_act) begin
                    state_d = ST_RUN;
                end else if (lap_act) begin
                    if (lap_hold_q) begin
                        lap_hold_d = 1'b0;
                    end else begin
                        sw_clr_d = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Prescaler: advances only while staying in RUN, holds through PAUSE, clears on IDLE entry.
    // The tick fires in the cycle the prescaler holds its last value, so it can never
    // coincide with IDLE or PAUSE (or with the clear pulse, which only occurs entering IDLE).
    always_comb begin
        presc_inc = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        presc_d   = presc_q;
        tick_en_d = 1'b0;
        if (state_d == ST_IDLE) begin
            presc_d = '0;
        end else if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            presc_d   = presc_inc;
            tick_en_d = (presc_inc == PRESC_LAST);
        end
    end

    // State, prescaler, edge and snapshot registers; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            go_q       <= 1'b0;
            lap_q      <= 1'b0;
            presc_q    <= '0;
            tick_en_q  <= 1'b0;
            sw_clr_q   <= 1'b0;
            lap_hold_q <= 1'b0;
            snapshot_q <= '0;
        end else begin
            state_q    <= state_d;
            go_q       <= go_d;
            lap_q      <= lap_d;
            presc_q    <= presc_d;
            tick_en_q  <= tick_en_d;
            sw_clr_q   <= sw_clr_d;
            lap_hold_q <= lap_hold_d;
            snapshot_q <= snapshot_d;
        end
    end

    // Outputs: registered controls plus the combinational lap display mux.
    always_comb begin
        tick_en  = tick_en_q;
        sw_clr   = sw_clr_q;
        lap_hold = lap_hold_q;
        state    = state_q;
        time_out = lap_hold_q ? snapshot_q : time_in;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV = 10 (CLK_HZ=1000, TICK_HZ=100).
module tb_stopwatch_ctrl;

    localparam logic [10:0] OPC = 11'b00001000000;

    logic        clk;
    logic        reset;
    logic        go;
    logic        lap;
    logic [10:0] op_code;
    logic [29:0] time_in;
    logic        tick_en;
    logic        sw_clr;
    logic        lap_hold;
    logic [29:0] time_out;
    logic [1:0]  state;

    int n_err = 0;
    int n_chk = 0;
    int cyc;

    stopwatch_ctrl #(
        .CLK_HZ (1000),
        .TICK_HZ(100),
        .OPC_STW(OPC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .go      (go),
        .lap     (lap),
        .op_code (op_code),
        .time_in (time_in),
        .tick_en (tick_en),
        .sw_clr  (sw_clr),
        .lap_hold(lap_hold),
        .time_out(time_out),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        go    = 1'b0;
        lap   = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        step();
        lap = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        go      = 1'b0;
        lap     = 1'b0;
        op_code = OPC;
        time_in = 30'h0;

        // Reset values
        time_in = 30'h0000777;
        do_reset();
        check("rst_state", state, 2'b00);
        check("rst_tick", tick_en, 1'b0);
        check("rst_clr", sw_clr, 1'b0);
        check("rst_hold", lap_hold, 1'b0);
        check("rst_tout", time_out, 30'h0000777);

        // Test 1: reset in the middle of RUN with lap held
        pulse_go();
        step();
        pulse_lap();
        check("t1_pre_hold", lap_hold, 1'b1);
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t1_state", state, 2'b00);
        check("t1_tick", tick_en, 1'b0);
        check("t1_hold", lap_hold, 1'b0);
        check("t1_clr", sw_clr, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("t1_notick_%0d", i), tick_en, 1'b0);
            step();
        end

        // Test 2: go at cycle 0, ticks at 10, 20, 30
        do_reset();
        op_code = OPC;
        pulse_go();
        cyc = 1;
        check("t2_run", state, 2'b01);
        while (cyc <= 31) begin
            check($sformatf("t2_tick_c%0d", cyc), tick_en, (cyc % 10 == 0) && (cyc > 0));
            step();
            cyc++;
        end

        // Test 3: pause at cycle 14 (prescaler=3), hold 50 cycles, resume
        do_reset();
        pulse_go();
        cyc = 1;
        while (cyc < 14) begin
            check($sformatf("t3_tick_c%0d", cyc), tick_en, cyc == 10);
            step();
            cyc++;
        end
        go = 1'b1;
        step();
        go = 1'b0;
        check("t3_pause", state, 2'b10);
        for (int i = 0; i < 50; i++) begin
            check($sformatf("t3_held_tick_%0d", i), tick_en, 1'b0);
            check($sformatf("t3_held_state_%0d", i), state, 2'b10);
            step();
        end
        pulse_go();
        check("t3_resume", state, 2'b01);
        for (int k = 1; k <= 12; k++) begin
            check($sformatf("t3_resume_tick_%0d", k), tick_en, k == 7);
            step();
        end

        // Test 4: lap snapshot freezes time_out, second lap releases it
        do_reset();
        time_in = 30'h0012345;
        pulse_go();
        step();
        pulse_lap();
        check("t4_hold", lap_hold, 1'b1);
        check("t4_tout0", time_out, 30'h0012345);
        time_in = 30'h0012399;
        #1;
        check("t4_tout1", time_out, 30'h0012345);
        step();
        time_in = 30'h0012400;
        #1;
        check("t4_tout2", time_out, 30'h0012345);
        pulse_lap();
        check("t4_release", lap_hold, 1'b0);
        check("t4_track0", time_out, 30'h0012400);
        time_in = 30'h0012401;
        #1;
        check("t4_track1", time_out, 30'h0012401);
        check("t4_state", state, 2'b01);

        // Test 5: lap in PAUSE clears (hold=0) or only releases the hold (hold=1)
        pulse_go();
        check("t5_pause", state, 2'b10);
        step();
        pulse_lap();
        check("t5_clr", sw_clr, 1'b1);
        check("t5_idle", state, 2'b00);
        check("t5_clr_notick", tick_en, 1'b0);
        step();
        check("t5_clr_width", sw_clr, 1'b0);
        check("t5_idle2", state, 2'b00);
        pulse_go();
        check("t5b_run", state, 2'b01);
        step();
        pulse_lap();
        check("t5b_hold", lap_hold, 1'b1);
        pulse_go();
        check("t5b_pause", state, 2'b10);
        check("t5b_hold_kept", lap_hold, 1'b1);
        step();
        pulse_lap();
        check("t5b_unhold", lap_hold, 1'b0);
        check("t5b_stay", state, 2'b10);
        check("t5b_noclr", sw_clr, 1'b0);
        step();
        check("t5b_noclr2", sw_clr, 1'b0);
        check("t5b_stay2", state, 2'b10);

        // Test 6: deselect, reselect with go held, simultaneous go+lap
        do_reset();
        op_code = 11'b00000000001;
        pulse_go();
        check("t6_desel", state, 2'b00);
        step();
        go = 1'b1;
        step();
        check("t6_desel_hi", state, 2'b00);
        op_code = OPC;
        step();
        check("t6_resel_noedge", state, 2'b00);
        go = 1'b0;
        step();
        go  = 1'b1;
        lap = 1'b1;
        step();
        go  = 1'b0;
        lap = 1'b0;
        check("t6_both_run", state, 2'b01);
        check("t6_both_nohold", lap_hold, 1'b0);
        op_code = 11'b00000000001;
        step();
        pulse_lap();
        check("t6_bg_nohold", lap_hold, 1'b0);
        check("t6_bg_run", state, 2'b01);
        repeat (7) step();
        check("t6_bg_tick", tick_en, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
